// File: rtl/pipe_seq_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state encodings,
// default timing parameters and the hold/drain counter sizing helper.
package pipe_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_e;

  localparam int unsigned DEF_RST_CYCLES   = 2;
  localparam int unsigned DEF_DRAIN_CYCLES = 4;

  // One counter serves both the reset hold and the halt drain, so size it for the longer.
  function automatic int unsigned seq_cnt_bits(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pipe_seq_perf.sv
// Performance counters for the pipeline sequencer: four free-running, wrapping
// event counters, each advanced by one on its increment enable.
module pipe_seq_perf #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc_haz,
  input  logic             i_inc_dmiss,
  input  logic             i_inc_imiss,
  input  logic             i_inc_flush,
  output logic [CNT_W-1:0] o_cnt_haz,
  output logic [CNT_W-1:0] o_cnt_dmiss,
  output logic [CNT_W-1:0] o_cnt_imiss,
  output logic [CNT_W-1:0] o_cnt_flush
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt_haz   <= '0;
      o_cnt_dmiss <= '0;
      o_cnt_imiss <= '0;
      o_cnt_flush <= '0;
    end else begin
      if (i_inc_haz)   o_cnt_haz   <= o_cnt_haz   + CNT_W'(1);
      if (i_inc_dmiss) o_cnt_dmiss <= o_cnt_dmiss + CNT_W'(1);
      if (i_inc_imiss) o_cnt_imiss <= o_cnt_imiss + CNT_W'(1);
      if (i_inc_flush) o_cnt_flush <= o_cnt_flush + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central stall/flush sequencer for the 5-stage RV32I pipeline: reset priming,
// stall/redirect arbitration and halt drain. Define PIPE_SEQ_PERF_EN for perf counters.
module pipeline_sequencer
  import pipe_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_haz_stall,
  input  logic             i_icache_busy,
  input  logic             i_dcache_busy,
  input  logic             i_redirect,
  input  logic             i_halt,
  output logic             o_rst_stall,
  output logic             o_stall_pc,
  output logic             o_stall_if_id,
  output logic             o_stall_id_ex,
  output logic             o_stall_ex_mem,
  output logic             o_flush_if_id,
  output logic             o_bubble_id_ex,
  output logic             o_bubble_mem_wb,
  output logic             o_redirect_en,
  output logic             o_halted,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_cnt_haz,
  output logic [CNT_W-1:0] o_cnt_dmiss,
  output logic [CNT_W-1:0] o_cnt_imiss,
  output logic [CNT_W-1:0] o_cnt_flush
);

  localparam int unsigned HC_W = seq_cnt_bits(RST_CYCLES, DRAIN_CYCLES);
  localparam logic [HC_W-1:0] RST_LAST   = HC_W'(RST_CYCLES - 1);
  localparam logic [HC_W-1:0] DRAIN_LAST = HC_W'(DRAIN_CYCLES - 1);

  seq_state_e      state_q, state_d;
  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
  logic            pending_q, pending_d;
  logic            take_dmiss, take_haz, take_redir, take_imiss, pend_flush;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      pending_q  <= pending_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d         = state_q;
    hold_cnt_d      = hold_cnt_q;
    pending_d       = pending_q;
    take_dmiss      = 1'b0;
    take_haz        = 1'b0;
    take_redir      = 1'b0;
    take_imiss      = 1'b0;
    pend_flush      = 1'b0;
    o_rst_stall     = 1'b0;
    o_stall_pc      = 1'b0;
    o_stall_if_id   = 1'b0;
    o_stall_id_ex   = 1'b0;
    o_stall_ex_mem  = 1'b0;
    o_flush_if_id   = 1'b0;
    o_bubble_id_ex  = 1'b0;
    o_bubble_mem_wb = 1'b0;
    o_redirect_en   = 1'b0;
    o_halted        = 1'b0;
    o_state         = state_q;

    unique case (state_q)
      ST_HOLD: begin
        o_rst_stall   = 1'b1;
        o_stall_pc    = 1'b1;
        o_flush_if_id = 1'b1;
        if (hold_cnt_q == RST_LAST) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end

      ST_RUN: begin
        if (i_dcache_busy) begin
          // Whole front end freezes; an unresolved branch stays in ID and reasserts later.
          take_dmiss      = 1'b1;
          o_stall_pc      = 1'b1;
          o_stall_if_id   = 1'b1;
          o_stall_id_ex   = 1'b1;
          o_stall_ex_mem  = 1'b1;
          o_bubble_mem_wb = 1'b1;
        end else if (i_haz_stall) begin
          take_haz       = 1'b1;
          o_stall_pc     = 1'b1;
          o_stall_if_id  = 1'b1;
          o_bubble_id_ex = 1'b1;
        end else if (i_redirect) begin
          take_redir    = 1'b1;
          o_redirect_en = 1'b1;
          o_flush_if_id = 1'b1;
        end else if (i_icache_busy) begin
          take_imiss    = 1'b1;
          o_stall_pc    = 1'b1;
          o_flush_if_id = 1'b1;
        end

        // The fetch outstanding across a redirect returns the old path; drop it once.
        if (pending_q && !i_icache_busy) begin
          pend_flush    = 1'b1;
          o_flush_if_id = 1'b1;
        end
        pending_d = take_redir ? i_icache_busy : (pending_q && i_icache_busy);

        if (i_halt && !i_dcache_busy) begin
          state_d    = ST_DRAIN;
          hold_cnt_d = '0;
        end
      end

      ST_DRAIN: begin
        pending_d = 1'b0;
        if (i_dcache_busy) begin
          o_stall_pc      = 1'b1;
          o_stall_if_id   = 1'b1;
          o_stall_id_ex   = 1'b1;
          o_stall_ex_mem  = 1'b1;
          o_bubble_mem_wb = 1'b1;
        end else begin
          o_stall_pc     = 1'b1;
          o_flush_if_id  = 1'b1;
          o_bubble_id_ex = 1'b1;
          if (hold_cnt_q == DRAIN_LAST) begin
            state_d    = ST_HALTED;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HC_W'(1);
          end
        end
      end

      ST_HALTED: begin
        pending_d       = 1'b0;
        o_stall_pc      = 1'b1;
        o_stall_if_id   = 1'b1;
        o_stall_id_ex   = 1'b1;
        o_stall_ex_mem  = 1'b1;
        o_bubble_mem_wb = 1'b1;
        o_halted        = 1'b1;
      end

      default: state_d = ST_HOLD;
    endcase

    // Reset is visible on the outputs in the same cycle, independent of the old state.
    if (i_rst) begin
      o_rst_stall     = 1'b1;
      o_stall_pc      = 1'b1;
      o_stall_if_id   = 1'b0;
      o_stall_id_ex   = 1'b0;
      o_stall_ex_mem  = 1'b0;
      o_flush_if_id   = 1'b1;
      o_bubble_id_ex  = 1'b0;
      o_bubble_mem_wb = 1'b0;
      o_redirect_en   = 1'b0;
      o_halted        = 1'b0;
      o_state         = ST_HOLD;
    end
  end

`ifdef PIPE_SEQ_PERF_EN
  pipe_seq_perf #(.CNT_W(CNT_W)) u_perf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_inc_haz   (take_haz),
    .i_inc_dmiss (take_dmiss),
    .i_inc_imiss (take_imiss),
    .i_inc_flush (take_redir | pend_flush),
    .o_cnt_haz   (o_cnt_haz),
    .o_cnt_dmiss (o_cnt_dmiss),
    .o_cnt_imiss (o_cnt_imiss),
    .o_cnt_flush (o_cnt_flush)
  );
`else
  assign o_cnt_haz   = '0;
  assign o_cnt_dmiss = '0;
  assign o_cnt_imiss = '0;
  assign o_cnt_flush = '0;
`endif

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline. It merges the hazard unit's load-use/branch stalls, I-cache and D-cache busy, ID-stage redirects (taken branch/JAL/JALR) and WB-stage halt (EBREAK/ECALL) into per-stage stall, bubble and flush controls. It also owns post-reset pipeline priming (drives the hazard unit's reset-stall input) and the halt-drain sequence.

Parameters:
RST_CYCLES, 2, cycles of reset hold after i_rst deasserts (>=1)
DRAIN_CYCLES, 4, cycles allowed for in-flight instructions to retire after halt (>=1)
CNT_W, 32, width of performance counters

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_haz_stall  input  1  hazard unit stall request (its o_stall_pc)
i_icache_busy  input  1  fetch not returning valid instruction this cycle
i_dcache_busy  input  1  MEM-stage access not complete this cycle
i_redirect  input  1  ID stage resolved a taken branch/jump
i_halt  input  1  valid EBREAK/ECALL in WB
o_rst_stall  output  1  to hazard unit i_rst_stall
o_stall_pc  output  1  hold PC
o_stall_if_id  output  1  hold IF/ID
o_stall_id_ex  output  1  hold ID/EX
o_stall_ex_mem  output  1  hold EX/MEM
o_flush_if_id  output  1  load NOP into IF/ID
o_bubble_id_ex  output  1  load NOP into ID/EX
o_bubble_mem_wb  output  1  load NOP into MEM/WB
o_redirect_en  output  1  PC loads redirect target
o_halted  output  1  core halted
o_state  output  2  FSM state (debug)
o_cnt_haz, o_cnt_dmiss, o_cnt_imiss, o_cnt_flush  output  CNT_W each  perf counters

Behaviour:
- One clock (i_clk); reset synchronous, active-high (i_rst). In reset: state=HOLD, hold counter=0, redirect-pending=0, counters=0. Outputs while i_rst=1: o_rst_stall=1, o_stall_pc=1, o_flush_if_id=1, all others 0.
- States: HOLD(0), RUN(1), DRAIN(2), HALTED(3). All outputs are combinational from state, registered flags and inputs (zero-latency).
- HOLD: o_rst_stall, o_stall_pc, o_flush_if_id = 1. Counter increments each cycle; after RST_CYCLES cycles with i_rst low -> RUN. i_halt/i_redirect ignored.
- RUN, first matching priority wins:
  1. i_dcache_busy: stall_pc, stall_if_id, stall_id_ex, stall_ex_mem = 1; bubble_mem_wb = 1; redirect and hazard ignored (the branch stays in ID and reasserts).
  2. i_haz_stall: stall_pc, stall_if_id, bubble_id_ex = 1; redirect ignored.
  3. i_redirect: redirect_en = 1, flush_if_id = 1. If i_icache_busy is also set, set redirect-pending.
  4. i_icache_busy: stall_pc = 1, flush_if_id = 1.
- Redirect-pending: on the first cycle with i_icache_busy=0 and pending=1, flush_if_id = 1 (discard stale fetch) and clear pending. A new redirect in that same cycle keeps pending=0 and flushes once.
- i_halt in RUN with i_dcache_busy=0 -> DRAIN. The halting instruction retires normally in that cycle.
- DRAIN: stall_pc, flush_if_id, bubble_id_ex = 1. Counter counts DRAIN_CYCLES, but does not advance while i_dcache_busy; the dcache freeze of rule 1 still applies. Counter done -> HALTED.
- HALTED: stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble_mem_wb = 1; o_halted = 1. Exit only via i_rst.
- Reset asserted in any state returns to HOLD the next cycle and clears pending and counters.

Optional Feature:
PIPE_SEQ_PERF_EN: when defined, counters increment by 1 per RUN cycle:
- o_cnt_haz: rule 2 taken
- o_cnt_dmiss: rule 1 taken
- o_cnt_imiss: rule 4 taken
- o_cnt_flush: each cycle o_flush_if_id is asserted by rule 3 or by the pending flush
Counters wrap modulo 2^CNT_W. When undefined, the counter ports exist and are tied to 0, and no counter flops are present.

Decomposition:
- pipe_seq_pkg (shared header): state encodings ST_HOLD/ST_RUN/ST_DRAIN/ST_HALTED, default RST_CYCLES/DRAIN_CYCLES.
- Sub-module pipe_seq_perf: four CNT_W counters with increment enables. Instantiated only under PIPE_SEQ_PERF_EN.

Test Plan:
- Reset with RST_CYCLES=2: release i_rst -> o_rst_stall=1 for exactly 2 cycles, then state=1 and all stalls 0.
- i_haz_stall=1 and i_redirect=1 same cycle -> stall_pc/stall_if_id/bubble_id_ex=1, redirect_en=0, flush_if_id=0; cnt_haz=1.
- i_redirect with i_icache_busy high for 3 cycles -> redirect_en=1 once; flush_if_id=1 in all 3 busy cycles and in the first non-busy cycle, then 0; cnt_flush=2.
- i_dcache_busy during i_haz_stall -> full freeze (stall_ex_mem=1, bubble_mem_wb=1, bubble_id_ex=0); cnt_dmiss counts busy cycles, cnt_haz unchanged.
- i_halt with DRAIN_CYCLES=4 plus 2 dcache-busy cycles mid-drain -> o_halted=1 exactly 6 cycles after DRAIN entry; stays set until i_rst, after which state=0.
